// File: rtl/line_sequencer_if.sv
// Command/table/drawer signal bundle for line_sequencer.
// master = the sequencer, slave = the controlling top level plus the drawer.
interface line_sequencer_if #(
    parameter int N_SEG = 8,
    parameter int AW    = $clog2(N_SEG)
);
    logic          start;
    logic          erase;
    logic [AW:0]   n_active;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [10:0]   tbl_x0, tbl_y0, tbl_x1, tbl_y1;
    logic          ld_reset;
    logic [10:0]   ld_x0, ld_y0, ld_x1, ld_y1;
    logic          ld_done;
    logic          color;
    logic          busy;
    logic          pass_done;
    logic          timeout_err;

    modport master (
        input  start, erase, n_active,
        input  tbl_we, tbl_addr, tbl_x0, tbl_y0, tbl_x1, tbl_y1,
        input  ld_done,
        output ld_reset, ld_x0, ld_y0, ld_x1, ld_y1,
        output color, busy, pass_done, timeout_err
    );

    modport slave (
        output start, erase, n_active,
        output tbl_we, tbl_addr, tbl_x0, tbl_y0, tbl_x1, tbl_y1,
        output ld_done,
        input  ld_reset, ld_x0, ld_y0, ld_x1, ld_y1,
        input  color, busy, pass_done, timeout_err
    );
endinterface

// File: rtl/line_sequencer.sv
// Walks a register table of line segments, kicking line_drawer once per
// segment and waiting for its done edge (or a timeout) before moving on.
module line_sequencer #(
    parameter int N_SEG   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    line_sequencer_if.master bus
);
    localparam int          AW       = $clog2(N_SEG);
    localparam logic [12:0] CNT_LAST = 13'(TIMEOUT - 1);
    localparam logic [AW:0] N_MAX    = (AW+1)'(N_SEG);

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] x1;
        logic [10:0] y1;
    } seg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   n_q, n_d;
    logic [12:0]   cnt_q, cnt_d;
    logic          done_q;
    logic          color_q, color_d;
    logic          terr_q, terr_d;
    logic          ld_reset_q, ld_reset_d;
    logic          busy_q, busy_d;
    logic          pd_q, pd_d;
    seg_t          seg_q, seg_d;
    seg_t          tbl_q [N_SEG];

    logic          done_rise;
    logic [AW:0]   n_clamp;
    logic          last_seg;

    assign done_rise = bus.ld_done & ~done_q;
    assign n_clamp   = (bus.n_active > N_MAX) ? N_MAX : bus.n_active;
    assign last_seg  = ({1'b0, idx_q} == (n_q - (AW+1)'(1)));

    // Table writes are only honoured while idle so a running pass sees a frozen table.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SEG; i++) tbl_q[i] <= '0;
        end else if (bus.tbl_we && state_q == S_IDLE) begin
            tbl_q[bus.tbl_addr] <= {bus.tbl_x0, bus.tbl_y0, bus.tbl_x1, bus.tbl_y1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            color_q    <= 1'b1;
            terr_q     <= 1'b0;
            ld_reset_q <= 1'b0;
            busy_q     <= 1'b0;
            pd_q       <= 1'b0;
            seg_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            done_q     <= bus.ld_done;
            color_q    <= color_d;
            terr_q     <= terr_d;
            ld_reset_q <= ld_reset_d;
            busy_q     <= busy_d;
            pd_q       <= pd_d;
            seg_q      <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        terr_d  = terr_q;
        seg_d   = seg_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d     = n_clamp;
                    idx_d   = '0;
                    color_d = ~bus.erase;
                    terr_d  = 1'b0;
                    state_d = (n_clamp == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                seg_d   = tbl_q[idx_q];
                state_d = S_KICK;
            end
            S_KICK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = (cnt_q != '1) ? cnt_q + 13'd1 : cnt_q;
                // A level already high on entry is ignored; only a fresh edge counts.
                if (done_rise) begin
                    state_d = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_NEXT;
                    terr_d  = 1'b1;
                end
            end
            S_NEXT: begin
                if (last_seg) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_LOAD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    assign ld_reset_d = (state_d == S_KICK);
    assign busy_d     = (state_d != S_IDLE);
    assign pd_d       = (state_d == S_FINISH);

    assign bus.ld_reset    = ld_reset_q;
    assign bus.ld_x0       = seg_q.x0;
    assign bus.ld_y0       = seg_q.y0;
    assign bus.ld_x1       = seg_q.x1;
    assign bus.ld_y1       = seg_q.y1;
    assign bus.color       = color_q;
    assign bus.busy        = busy_q;
    assign bus.pass_done   = pd_q;
    assign bus.timeout_err = terr_q;
endmodule
